// File: rtl/matmul_pkg.sv
// ---------------------------------------------------------------------------
// matmul_pkg: shared sizes, FSM state type and row-major index helper.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package matmul_pkg;
  localparam int DATA_W    = 8;
  localparam int DIM       = 3;
  localparam int ACC_W     = 2 * DATA_W + $clog2(DIM);
  localparam int OUT_BYTES = (ACC_W + 7) / 8;
  localparam int OUT_W     = OUT_BYTES * 8;
  localparam int NEL       = DIM * DIM;
  localparam int IDX_W     = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int EL_W      = (NEL > 1) ? $clog2(NEL) : 1;
  localparam int BYTE_W    = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    STREAM  = 2'd2,
    DONE    = 2'd3
  } mm_state_t;

  function automatic int idx(input int row, input int col);
    return row * DIM + col;
  endfunction
endpackage

`default_nettype wire

// File: rtl/matmul_stream_engine_mac_unit.sv
// ---------------------------------------------------------------------------
// mac_unit: single multiplier feeding a registered accumulator.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mac_unit
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc_next
);

  logic [ACC_W-1:0]               acc_q, acc_d;
  logic [ACC_W-1:0]               prod_ext;
  logic [2*DATA_W-1:0]            prod_u;
  logic signed [2*DATA_W-1:0]     prod_s;

  always_comb begin
    prod_u   = a * b;
    prod_s   = $signed(a) * $signed(b);
    // Size casts extend according to the signedness of each product.
    prod_ext = signed_mode ? ACC_W'(prod_s) : ACC_W'(prod_u);
    acc_next = (clr ? '0 : acc_q) + prod_ext;
    acc_d    = en ? acc_next : acc_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

`default_nettype wire

// File: rtl/matmul_stream_engine.sv
// ---------------------------------------------------------------------------
// matmul_stream_engine: C = A x B with one MAC, results streamed MSB-first.
// Optional signed arithmetic via macro MATMUL_SIGNED_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module matmul_stream_engine
  import matmul_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DIM*DIM*DATA_W-1:0] a_flat,
  input  logic [DIM*DIM*DATA_W-1:0] b_flat,
  output logic [7:0]                data_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      finished
);

`ifdef MATMUL_SIGNED_EN
  localparam logic SIGNED_MODE = 1'b1;
`else
  localparam logic SIGNED_MODE = 1'b0;
`endif

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIM - 1);
  localparam logic [EL_W-1:0]   EL_LAST   = EL_W'(NEL - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(OUT_BYTES - 1);

  mm_state_t          state_q, state_d;
  logic [IDX_W-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
  logic [EL_W-1:0]    e_q, e_d;
  logic [BYTE_W-1:0]  b_q, b_d;
  logic [ACC_W-1:0]   c_q [NEL];
  logic [ACC_W-1:0]   c_d [NEL];
  logic [7:0]         data_out_q, data_out_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               finished_q, finished_d;

  logic [DATA_W-1:0]  mac_a, mac_b;
  logic [ACC_W-1:0]   acc_next;
  logic [OUT_W-1:0]   res_ext;
  int                 a_base, b_base;

  always_comb begin
    a_base = idx(int'(i_q), int'(k_q)) * DATA_W;
    b_base = idx(int'(k_q), int'(j_q)) * DATA_W;
    mac_a  = a_flat[a_base +: DATA_W];
    mac_b  = b_flat[b_base +: DATA_W];
  end

  mac_unit u_mac (
    .clk         (clk),
    .reset       (reset),
    .en          (state_q == COMPUTE),
    .clr         (k_q == '0),
    .signed_mode (SIGNED_MODE),
    .a           (mac_a),
    .b           (mac_b),
    .acc_next    (acc_next)
  );

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    e_d        = e_q;
    b_d        = b_q;
    c_d        = c_q;
    res_ext    = '0;
    data_out_d = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COMPUTE;
          i_d = '0;
          j_d = '0;
          k_d = '0;
          e_d = '0;
          b_d = '0;
        end
      end
      COMPUTE: begin
        if (k_q == IDX_LAST) begin
          c_d[EL_W'(idx(int'(i_q), int'(j_q)))] = acc_next;
          k_d = '0;
          if (j_q == IDX_LAST) begin
            j_d = '0;
            if (i_q == IDX_LAST) begin
              i_d     = '0;
              e_d     = '0;
              b_d     = '0;
              state_d = STREAM;
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (b_q == BYTE_LAST) begin
            b_d = '0;
            if (e_q == EL_LAST) state_d = DONE;
            else                e_d = e_q + 1'b1;
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so valid/data appear together.
    busy_d      = (state_d == COMPUTE) || (state_d == STREAM);
    finished_d  = (state_d == DONE);
    out_valid_d = (state_d == STREAM);
    if (out_valid_d) begin
      res_ext    = SIGNED_MODE ? OUT_W'($signed(c_d[e_d])) : OUT_W'(c_d[e_d]);
      data_out_d = 8'(res_ext >> (8 * (OUT_BYTES - 1 - int'(b_d))));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      e_q         <= '0;
      b_q         <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      for (int n = 0; n < NEL; n++) c_q[n] <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      e_q         <= e_d;
      b_q         <= b_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
      for (int n = 0; n < NEL; n++) c_q[n] <= c_d[n];
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign finished  = finished_q;

endmodule

`default_nettype wire
